lime_io_bridge: RTL and testbench

Buffered I/O stage wrapped around the 16-bit multi-cycle core.
- Upstream: accepts words from an external producer over a valid/ready handshake, queues them, and presents the head word on the core's main_input.
- Downstream: captures the core's main_output on a write strobe, queues it, and drains it to an external consumer over valid/ready.
- Core-side strobes come from the core's I/O-address decode.

---
 rtl/lime_io_pkg.sv | 20 ++
 rtl/lime_io_if.sv | 32 +++
 rtl/lime_sync_fifo.sv | 69 ++++++
 rtl/lime_io_bridge.sv | 82 ++++++++
 tb/tb_lime_io_bridge.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lime_io_pkg.sv
// Shared defaults for the lime I/O bridge: word width, queue depths and
// bit positions of the sticky status flags.
package lime_io_pkg;

    localparam int LIME_WIDTH     = 16;
    localparam int LIME_IN_DEPTH  = 4;
    localparam int LIME_OUT_DEPTH = 4;

    localparam int FLAG_IN_UNDERFLOW = 0;
    localparam int FLAG_OUT_OVERFLOW = 1;
    localparam int FLAG_BITS         = 2;

    typedef logic [FLAG_BITS-1:0] flags_t;

    // A flag event in the same cycle as a clear wins, so the flag stays set.
    function automatic flags_t update_flags(flags_t cur, flags_t events, logic clear);
        return (clear ? '0 : cur) | events;
    endfunction

endpackage

// File: rtl/lime_io_if.sv
// Producer/consumer handshakes plus the core-side data and strobes seen by
// the bridge; the bridge takes the slave view.
interface lime_io_if
    import lime_io_pkg::*;
#(
    parameter int WIDTH = LIME_WIDTH
) ();

    logic [WIDTH-1:0] ext_in_data;
    logic             ext_in_valid;
    logic             ext_in_ready;
    logic [WIDTH-1:0] main_input;
    logic             proc_in_ack;
    logic [WIDTH-1:0] main_output;
    logic             proc_out_strobe;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_valid;
    logic             ext_out_ready;

    modport slave (
        input  ext_in_data, ext_in_valid, proc_in_ack, main_output,
               proc_out_strobe, ext_out_ready,
        output ext_in_ready, main_input, ext_out_data, ext_out_valid
    );

    modport master (
        output ext_in_data, ext_in_valid, proc_in_ack, main_output,
               proc_out_strobe, ext_out_ready,
        input  ext_in_ready, main_input, ext_out_data, ext_out_valid
    );

endinterface

// File: rtl/lime_sync_fifo.sv
// Single-clock FIFO with binary wrapping pointers and an occupancy count;
// push while full and pop while empty are ignored.
module lime_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_d + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_d - 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/lime_io_bridge.sv
// Buffered I/O stage around the 16-bit core: input queue feeding main_input,
// output queue capturing main_output, and sticky underflow/overflow flags.
module lime_io_bridge
    import lime_io_pkg::*;
#(
    parameter int WIDTH     = LIME_WIDTH,
    parameter int IN_DEPTH  = LIME_IN_DEPTH,
    parameter int OUT_DEPTH = LIME_OUT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    lime_io_if.slave                    io,
    output logic [$clog2(IN_DEPTH):0]   in_count,
    output logic [$clog2(OUT_DEPTH):0]  out_count,
    output logic                        in_underflow,
    output logic                        out_overflow,
    input  logic                        clear_flags
);

    logic [WIDTH-1:0] in_head, out_head;
    logic             in_full, in_empty, out_full, out_empty;
    logic             in_push, in_pop, out_push, out_pop;
    logic [WIDTH-1:0] hold_q, hold_d;
    flags_t           flags_q, flags_d, flag_events;

    // Ready depends only on registered fullness: a pop never frees a slot for the same edge.
    assign in_push  = io.ext_in_valid && !in_full;
    assign in_pop   = io.proc_in_ack && !in_empty;
    assign out_push = io.proc_out_strobe && !out_full;
    assign out_pop  = io.ext_out_ready && !out_empty;

    lime_sync_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (io.ext_in_data),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    lime_sync_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (out_push),
        .pop   (out_pop),
        .wdata (io.main_output),
        .rdata (out_head),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    always_comb begin
        flag_events                    = '0;
        flag_events[FLAG_IN_UNDERFLOW] = io.proc_in_ack && in_empty;
        flag_events[FLAG_OUT_OVERFLOW] = io.proc_out_strobe && out_full;
        flags_d                        = update_flags(flags_q, flag_events, clear_flags);
        hold_d                         = in_pop ? in_head : hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            flags_q <= '0;
        end else begin
            hold_q  <= hold_d;
            flags_q <= flags_d;
        end
    end

    // With the input queue drained the core keeps seeing the last word it consumed.
    assign io.main_input    = in_empty ? hold_q : in_head;
    assign io.ext_in_ready  = !in_full;
    assign io.ext_out_valid = !out_empty;
    assign io.ext_out_data  = out_head;
    assign in_underflow     = flags_q[FLAG_IN_UNDERFLOW];
    assign out_overflow     = flags_q[FLAG_OUT_OVERFLOW];

endmodule

// File: tb/tb_lime_io_bridge.sv
// Bench for lime_io_bridge: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_lime_io_bridge;

    localparam int W     = 16;
    localparam int IN_D  = 4;
    localparam int OUT_D = 4;

    logic       clk;
    logic       rst_n;
    logic       clear_flags;
    logic [2:0] in_count, out_count;
    logic       in_underflow, out_overflow;

    int total = 0;
    int bad   = 0;

    lime_io_if #(.WIDTH(W)) io ();

    lime_io_bridge #(.WIDTH(W), .IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io           (io),
        .in_count     (in_count),
        .out_count    (out_count),
        .in_underflow (in_underflow),
        .out_overflow (out_overflow),
        .clear_flags  (clear_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues following the handshake rules.
    logic [W-1:0] m_in[$];
    logic [W-1:0] m_out[$];
    logic [W-1:0] m_hold;
    bit           m_uf, m_of;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in.delete();
            m_out.delete();
            m_hold = '0;
            m_uf   = 1'b0;
            m_of   = 1'b0;
        end else begin
            automatic int in_n  = m_in.size();
            automatic int out_n = m_out.size();
            automatic bit uf_ev = io.proc_in_ack && (in_n == 0);
            automatic bit of_ev = io.proc_out_strobe && (out_n == OUT_D);
            if (io.proc_in_ack && in_n > 0) m_hold = m_in.pop_front();
            if (io.ext_in_valid && in_n < IN_D) m_in.push_back(io.ext_in_data);
            if (io.ext_out_ready && out_n > 0) void'(m_out.pop_front());
            if (io.proc_out_strobe && out_n < OUT_D) m_out.push_back(io.main_output);
            m_uf = (m_uf && !clear_flags) || uf_ev;
            m_of = (m_of && !clear_flags) || of_ev;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model.in_count", 32'(in_count), m_in.size());
            check("model.out_count", 32'(out_count), m_out.size());
            check("model.ext_in_ready", 32'(io.ext_in_ready), 32'(m_in.size() < IN_D));
            check("model.main_input", 32'(io.main_input),
                  32'((m_in.size() > 0) ? m_in[0] : m_hold));
            check("model.ext_out_valid", 32'(io.ext_out_valid), 32'(m_out.size() > 0));
            if (m_out.size() > 0) check("model.ext_out_data", 32'(io.ext_out_data), 32'(m_out[0]));
            check("model.in_underflow", 32'(in_underflow), 32'(m_uf));
            check("model.out_overflow", 32'(out_overflow), 32'(m_of));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        io.ext_in_data     = '0;
        io.ext_in_valid    = 1'b0;
        io.proc_in_ack     = 1'b0;
        io.main_output     = '0;
        io.proc_out_strobe = 1'b0;
        io.ext_out_ready   = 1'b0;
        clear_flags        = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        check("rst.in_count", 32'(in_count), 0);
        check("rst.out_count", 32'(out_count), 0);
        check("rst.ext_in_ready", 32'(io.ext_in_ready), 1);
        check("rst.ext_out_valid", 32'(io.ext_out_valid), 0);
        check("rst.main_input", 32'(io.main_input), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Basic push / ack sequence.
        io.ext_in_valid = 1'b1;
        io.ext_in_data  = 16'h1234;
        tick();
        check("in.latency", 32'(io.main_input), 32'h1234);
        io.ext_in_data = 16'hBEEF;
        tick();
        io.ext_in_valid = 1'b0;
        check("in.count2", 32'(in_count), 2);
        io.proc_in_ack = 1'b1;
        tick();
        io.proc_in_ack = 1'b0;
        check("in.ack1", 32'(io.main_input), 32'hBEEF);
        io.proc_in_ack = 1'b1;
        tick();
        io.proc_in_ack = 1'b0;
        check("in.empty_count", 32'(in_count), 0);
        check("in.hold", 32'(io.main_input), 32'hBEEF);

        // Fill, then pop with a concurrent push attempt: no bypass.
        io.ext_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            io.ext_in_data = 16'h00A0 + 16'(i);
            tick();
        end
        check("in.full_ready", 32'(io.ext_in_ready), 0);
        check("in.full_count", 32'(in_count), 4);
        io.ext_in_data = 16'h00A4;
        io.proc_in_ack = 1'b1;
        tick();
        io.ext_in_valid = 1'b0;
        check("in.nobypass_count", 32'(in_count), 3);
        check("in.ready_back", 32'(io.ext_in_ready), 1);
        check("in.head_a1", 32'(io.main_input), 32'h00A1);
        repeat (3) tick();
        io.proc_in_ack = 1'b0;
        check("in.drained_hold", 32'(io.main_input), 32'h00A3);

        // Underflow flag and clear priority.
        io.proc_in_ack = 1'b1;
        tick();
        io.proc_in_ack = 1'b0;
        check("uf.set", 32'(in_underflow), 1);
        clear_flags = 1'b1;
        tick();
        check("uf.cleared", 32'(in_underflow), 0);
        io.proc_in_ack = 1'b1;
        tick();
        io.proc_in_ack = 1'b0;
        check("uf.event_wins", 32'(in_underflow), 1);
        tick();
        clear_flags = 1'b0;
        check("uf.cleared2", 32'(in_underflow), 0);
        io.ext_in_valid = 1'b1;
        io.ext_in_data  = 16'hC0C0;
        io.proc_in_ack  = 1'b1;
        tick();
        io.ext_in_valid = 1'b0;
        io.proc_in_ack  = 1'b0;
        check("uf.push_ack_count", 32'(in_count), 1);
        check("uf.push_ack_flag", 32'(in_underflow), 1);
        check("uf.push_ack_head", 32'(io.main_input), 32'hC0C0);
        io.proc_in_ack = 1'b1;
        tick();
        io.proc_in_ack = 1'b0;
        clear_flags    = 1'b1;
        tick();
        clear_flags = 1'b0;

        // Output overflow with a stalled consumer, then in-order drain.
        io.proc_out_strobe = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            io.main_output = 16'(k);
            tick();
        end
        io.proc_out_strobe = 1'b0;
        check("out.full_count", 32'(out_count), 4);
        check("out.overflow", 32'(out_overflow), 1);
        check("out.valid", 32'(io.ext_out_valid), 1);
        repeat (2) tick();
        check("out.stall_stable", 32'(io.ext_out_data), 1);
        for (int k = 1; k <= 4; k++) begin
            check("out.drain_order", 32'(io.ext_out_data), 32'(k));
            io.ext_out_ready = 1'b1;
            tick();
            io.ext_out_ready = 1'b0;
        end
        check("out.empty_valid", 32'(io.ext_out_valid), 0);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("out.of_cleared", 32'(out_overflow), 0);

        // Strobe into a full queue is dropped even when the consumer pops.
        io.proc_out_strobe = 1'b1;
        for (int k = 0; k < 4; k++) begin
            io.main_output = 16'h0041 + 16'(k);
            tick();
        end
        io.main_output   = 16'h0045;
        io.ext_out_ready = 1'b1;
        tick();
        io.proc_out_strobe = 1'b0;
        io.ext_out_ready   = 1'b0;
        check("out.full_pop_count", 32'(out_count), 3);
        check("out.full_pop_of", 32'(out_overflow), 1);
        check("out.full_pop_head", 32'(io.ext_out_data), 32'h0042);
        io.ext_out_ready = 1'b1;
        repeat (3) tick();
        io.ext_out_ready = 1'b0;
        clear_flags      = 1'b1;
        tick();
        clear_flags = 1'b0;

        // Simultaneous strobe and pop with two queued words.
        io.proc_out_strobe = 1'b1;
        io.main_output     = 16'h0011;
        tick();
        io.main_output = 16'h0022;
        tick();
        io.main_output   = 16'h0033;
        io.ext_out_ready = 1'b1;
        tick();
        io.proc_out_strobe = 1'b0;
        io.ext_out_ready   = 1'b0;
        check("out.both_count", 32'(out_count), 2);
        check("out.both_head", 32'(io.ext_out_data), 32'h0022);
        check("out.both_no_of", 32'(out_overflow), 0);
        io.ext_out_ready = 1'b1;
        tick();
        check("out.both_next", 32'(io.ext_out_data), 32'h0033);
        tick();
        io.ext_out_ready = 1'b0;

        // Asynchronous reset with words queued on both sides.
        io.ext_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io.ext_in_data     = 16'h00D1 + 16'(i);
            io.proc_out_strobe = (i < 2);
            io.main_output     = 16'h00E1 + 16'(i);
            tick();
        end
        idle();
        check("rst_mid.pre_count", 32'(in_count), 3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.in_count", 32'(in_count), 0);
        check("rst_mid.out_count", 32'(out_count), 0);
        check("rst_mid.ext_out_valid", 32'(io.ext_out_valid), 0);
        check("rst_mid.main_input", 32'(io.main_input), 0);
        check("rst_mid.ext_in_ready", 32'(io.ext_in_ready), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("rst_mid.after_count", 32'(in_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
